// File: rtl/crc_req_arbiter.sv
// Round-robin front end sharing one bit-serial CRC engine between a generator (ch0) and a checker (ch1).
// Latency: result pulse WIDTH+1 edges after the accepting edge; optional CRC_INIT_ONES_EN seeds CRC with all ones.
// Backpressure: ready only in IDLE and only for the granted channel; the other requester waits with valid held.

module crc_req_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH:0]   polynom_i,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [WIDTH-1:0] req1_crc,
  output logic             req1_ready,
  output logic             busy,
  output logic             out_valid,
  output logic             out_id,
  output logic [WIDTH-1:0] CRC,
  output logic             OK
);

  localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef CRC_INIT_ONES_EN
  localparam logic [WIDTH-1:0] CRC_INIT = {WIDTH{1'b1}};
`else
  localparam logic [WIDTH-1:0] CRC_INIT = {WIDTH{1'b0}};
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, poly_q, crc_q, exp_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               last_grant_q, out_id_q, ok_q, out_valid_q;
  logic               gnt_id, hs, fb, idle_ok;
  logic [WIDTH-1:0]   crc_next;
  logic               unused_poly_msb;

  // The polynomial's top coefficient is implicit in the shift-and-xor step.
  assign unused_poly_msb = polynom_i[WIDTH];

  // Contention goes to the channel that did not win last time.
  assign gnt_id     = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
  assign idle_ok    = (state_q == IDLE) && !rst;
  assign req0_ready = idle_ok && req0_valid && !gnt_id;
  assign req1_ready = idle_ok && req1_valid && gnt_id;
  assign hs         = req0_ready || req1_ready;

  assign fb       = crc_q[WIDTH-1] ^ shreg_q[WIDTH-1];
  assign crc_next = {crc_q[WIDTH-2:0], 1'b0} ^ (fb ? poly_q : {WIDTH{1'b0}});

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(WIDTH - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q      <= '0;
      poly_q       <= '0;
      crc_q        <= '0;
      exp_q        <= '0;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      out_id_q     <= 1'b0;
      ok_q         <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hs) begin
            shreg_q      <= gnt_id ? req1_data : req0_data;
            poly_q       <= polynom_i[WIDTH-1:0];
            if (gnt_id) exp_q <= req1_crc;
            crc_q        <= CRC_INIT;
            cnt_q        <= '0;
            out_id_q     <= gnt_id;
            last_grant_q <= gnt_id;
            ok_q         <= 1'b0;
          end
        end
        SHIFT: begin
          crc_q   <= crc_next;
          shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
          cnt_q   <= cnt_q + CNT_W'(1);
        end
        DONE: begin
          out_valid_q <= 1'b1;
          ok_q        <= (crc_q == exp_q) && out_id_q;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign CRC       = crc_q;
  assign OK        = ok_q;

endmodule

// File: doc/crc_req_arbiter.md
Name: crc_req_arbiter

Overview:
- Shares one bit-serial CRC engine between two requesters.
  - Channel 0 is the generator: it receives the computed CRC.
  - Channel 1 is the checker: the computed CRC is compared with a supplied expected CRC.
- Round-robin arbitration, valid/ready handshake on each request port, single result port tagged with the channel id.
- Sits between the transmit/receive word sources and the downstream framing logic.

Parameters:
- WIDTH, 16, data word and CRC width in bits; the polynomial is WIDTH+1 bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- polynom_i  in  WIDTH+1  generator polynomial; bit WIDTH is implicit, bits [WIDTH-1:0] are used.
- req0_valid  in  1  channel 0 request.
- req0_data  in  WIDTH  channel 0 data word.
- req0_ready  out  1  channel 0 accepted this cycle.
- req1_valid  in  1  channel 1 request.
- req1_data  in  WIDTH  channel 1 data word.
- req1_crc  in  WIDTH  channel 1 expected CRC.
- req1_ready  out  1  channel 1 accepted this cycle.
- busy  out  1  engine occupied (state != IDLE).
- out_valid  out  1  result valid, one-cycle pulse.
- out_id  out  1  channel that owns the result.
- CRC  out  WIDTH  computed CRC.
- OK  out  1  channel 1 only: CRC == latched expected CRC; always 0 for channel 0.

Behaviour:
- Reset (asynchronous, immediate on rst=1):
  - state=IDLE; CRC=0, OK=0, out_valid=0, out_id=0, busy=0.
  - Internal shift register, bit counter and latched expected CRC cleared.
  - last_grant=1, so channel 0 wins the first contention.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - Grant rule, combinational from valids and last_grant:
    - only one valid → that channel;
    - both valid → the channel != last_grant.
  - reqN_ready=1 only in IDLE, only for the granted channel, and only while its valid=1. The two readys are never both 1.
  - On the handshake edge:
    - latch data into the shift register, polynom_i[WIDTH-1:0] into the poly register, and req1_crc if channel 1;
    - clear the CRC register to the initial value, clear the counter;
    - set out_id and last_grant to the granted channel;
    - go to SHIFT.
- SHIFT:
  - One bit per clock, MSB first.
  - fb = CRC[WIDTH-1] ^ bit.
  - CRC <= {CRC[WIDTH-2:0],1'b0} ^ (fb ? poly : 0).
  - Shift register moves left; counter increments.
  - After exactly WIDTH edges in SHIFT, go to DONE.
  - No augmentation, no reflection, no final XOR.
- DONE:
  - out_valid=1, OK valid, for exactly one cycle; next edge → IDLE.
  - CRC, OK and out_id hold their values until the next handshake reloads them.
- Latency and throughput:
  - out_valid goes high WIDTH+1 edges after the handshake edge.
  - Minimum spacing between accepted requests is WIDTH+2 cycles.
- Requesters must hold valid and data stable until ready. Dropping valid before ready is legal; nothing is captured.
- polynom_i, reqN_data and req1_crc changes after the handshake edge have no effect on the running computation.
- Requests arriving during SHIFT or DONE wait; ready stays 0.
- rst during SHIFT or DONE aborts immediately: no out_valid for the aborted request, last_grant back to 1.
- OK is registered in DONE: (CRC == expected) && out_id==1.

Optional Feature:
- Macro CRC_INIT_ONES_EN.
- Defined: the CRC register initial value loaded at handshake is all ones ({WIDTH{1'b1}}).
- Undefined: the initial value is all zeros.
- Reset value of the CRC output is 0 in both builds.
- All Test Plan values below assume the macro undefined.

Test Plan:
- Reset: rst=1 with both valids high → readys=0, out_valid=0, CRC=0, OK=0. After rst=0, channel 0 is granted first.
- Channel 0, data 16'h0001, polynom_i 17'h1_8005 → out_valid 17 edges after handshake; CRC=16'h8005, out_id=0, OK=0.
- Channel 1, data 16'h0002, req1_crc 16'h800F → CRC=16'h800F, out_id=1, OK=1. Repeat with req1_crc 16'h800E → OK=0.
- Both valids held high continuously → grants alternate 0,1,0,1 and results are spaced 18 cycles apart. Data 16'h0000 → CRC=16'h0000.
- rst pulsed 8 cycles into SHIFT for a channel 1 request → outputs cleared immediately, no out_valid. With both valid afterwards, channel 0 is granted.
- polynom_i changed to 17'h1_1021 two cycles after accepting data 16'h0001 with 17'h1_8005 → result is still 16'h8005.
